rv_iret_trace_buf: RTL

RV_IRET_TRACE_BUF -- requirements
Module: rv_iret_trace_buf

---
 rtl/rv_iret_trace_pkg.sv | 23 ++
 rtl/rv_iret_trace_fifo.sv | 55 +++++
 rtl/rv_iret_trace_buf.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rv_iret_trace_pkg.sv
// Shared types and constants for the retirement trace buffer.
// Fixed-width entry metadata, overflow state encoding and the drop counter helper.
package rv_iret_trace_pkg;

  localparam int SEQ_W  = 64;
  localparam int DROP_W = 16;

  typedef enum logic {
    NORMAL = 1'b0,
    OVF    = 1'b1
  } ovf_state_t;

  // Width-independent part of a trace entry; the XLEN/FLEN fields are added by the top.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      insn;
  } meta_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rv_iret_trace_fifo.sv
// Generic W-bit FIFO with explicit occupancy counter; head is read straight from storage.
// Latency: an entry written at edge N is visible on pop_dat after edge N.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module rv_iret_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/rv_iret_trace_buf.sv
// Retirement trace buffer: tags each iret with a 64-bit seq and queues it; RV_IRET_TRACE_FRES_EN stores fres.
// Latency: entry visible on trc_* the cycle after the retiring edge; outputs come straight from storage.
// Backpressure: none upstream; a full buffer drops the retirement, sets sticky ovf and counts it.
module rv_iret_trace_buf
  import rv_iret_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iret,
  input  logic [XLEN-1:0]         addr,
  input  logic [31:0]             insn,
  input  logic [XLEN-1:0]         ires,
  input  logic [FLEN-1:0]         fres,
  output logic                    trc_valid,
  input  logic                    trc_ready,
  output logic [XLEN-1:0]         trc_addr,
  output logic [31:0]             trc_insn,
  output logic [XLEN-1:0]         trc_ires,
  output logic [FLEN-1:0]         trc_fres,
  output logic [SEQ_W-1:0]        trc_seq,
  output logic                    ovf,
  output logic [DROP_W-1:0]       drop_cnt,
  input  logic                    ovf_clr,
  output logic [$clog2(DEPTH):0]  level
);

`ifdef RV_IRET_TRACE_FRES_EN
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] ires;
    logic [FLEN-1:0] fres;
    meta_t           meta;
  } entry_t;
`else
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] ires;
    meta_t           meta;
  } entry_t;
`endif

  entry_t           push_ent;
  entry_t           head_ent;
  logic             full;
  logic             empty;
  logic             pop;
  logic             drop;
  logic [SEQ_W-1:0] seq_q;
  ovf_state_t       state;
  ovf_state_t       state_nxt;

  assign trc_valid = ~empty;
  assign pop       = trc_valid & trc_ready;
  assign drop      = iret & full & ~pop;

  always_comb begin
    push_ent           = '0;
    push_ent.addr      = addr;
    push_ent.ires      = ires;
    push_ent.meta.insn = insn;
    push_ent.meta.seq  = seq_q;
`ifdef RV_IRET_TRACE_FRES_EN
    push_ent.fres      = fres;
`endif
  end

  rv_iret_trace_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (iret),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head_ent),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign trc_addr = head_ent.addr;
  assign trc_ires = head_ent.ires;
  assign trc_insn = head_ent.meta.insn;
  assign trc_seq  = head_ent.meta.seq;
`ifdef RV_IRET_TRACE_FRES_EN
  assign trc_fres = head_ent.fres;
`else
  logic unused_fres;
  assign unused_fres = ^fres;
  assign trc_fres    = '0;
`endif

  // Dropped retirements still consume a sequence number so the sink can see the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q    <= '0;
      drop_cnt <= '0;
      state    <= NORMAL;
    end else begin
      state <= state_nxt;
      if (iret) seq_q <= seq_q + 1'b1;
      if (drop)         drop_cnt <= ovf_clr ? DROP_W'(1) : sat_inc(drop_cnt);
      else if (ovf_clr) drop_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    ovf       = 1'b0;
    case (state)
      NORMAL: if (drop) state_nxt = OVF;
      OVF: begin
        ovf = 1'b1;
        if (ovf_clr && !drop) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

endmodule
